inst_fetch: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the architectural fetch PC and issues one instruction-memory read at a time.
- Delivers {inst_o, pc_o, valid_o} to the decode stage and honours decode's pause.
- Applies the next-PC redirect computed by decode after the delay slot, per MIPS branch-delay semantics.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/inst_fetch_if.sv | 47 ++++
 rtl/inst_fetch_if_id_reg.sv | 43 ++++
 rtl/inst_fetch.sv | 144 ++++++++++++++
 tb/tb_inst_fetch.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: word size, reset PC, NOP encoding
// and the fetch FSM state encoding.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] INST_NOP_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] INST_BYTES   = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } fetch_state_e;

    // Sequential next PC; wraps modulo 2^32.
    function automatic logic [WORD_W-1:0] pc_incr(input logic [WORD_W-1:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: decode-side controls, instruction-memory handshake and the
// IF/ID outputs. Optional perf counters appear when INST_FETCH_PERF_EN is defined.
interface inst_fetch_if;
    import cpu_pkg::*;

    // Decode side
    logic              pause_i;
    logic              redirect_i;
    logic [WORD_W-1:0] redirect_pc_i;
    // Instruction memory
    logic              imem_req_o;
    logic [WORD_W-1:0] imem_addr_o;
    logic              imem_rvalid_i;
    logic [WORD_W-1:0] imem_rdata_i;
    // IF/ID register
    logic [WORD_W-1:0] inst_o;
    logic [WORD_W-1:0] pc_o;
    logic              valid_o;

`ifdef INST_FETCH_PERF_EN
    logic [31:0]       perf_fetched_o;
    logic [31:0]       perf_stall_o;

    modport master (
        input  pause_i, redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, inst_o, pc_o, valid_o,
        output perf_fetched_o, perf_stall_o
    );

    modport slave (
        output pause_i, redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, inst_o, pc_o, valid_o,
        input  perf_fetched_o, perf_stall_o
    );
`else
    modport master (
        input  pause_i, redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, inst_o, pc_o, valid_o
    );

    modport slave (
        output pause_i, redirect_i, redirect_pc_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, inst_o, pc_o, valid_o
    );
`endif

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register with load / bubble / hold control. Load wins over
// bubble; with neither asserted the contents hold. Also used as the skid buffer.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] INST_NOP = INST_NOP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [WORD_W-1:0] i_inst,
    input  logic [WORD_W-1:0] i_pc,
    output logic [WORD_W-1:0] o_inst,
    output logic [WORD_W-1:0] o_pc,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_inst;
    logic [WORD_W-1:0] r_pc;
    logic              r_valid;

    // Register update: load a new instruction, insert a bubble, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst  <= INST_NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst  <= i_inst;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (i_bubble) begin
            r_inst  <= INST_NOP;
            r_valid <= 1'b0;
        end
    end

    assign o_inst  = r_inst;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage with IF/ID register and one-entry skid buffer.
// One outstanding imem read; decode redirects take effect after the delay slot.
// Optional perf counters are enabled by defining INST_FETCH_PERF_EN.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] INST_NOP = INST_NOP_DEF
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  fetch_bus
);

    fetch_state_e      r_state;
    logic [WORD_W-1:0] r_fetch_pc;
    logic [WORD_W-1:0] r_redir_tgt;
    logic              r_redir_pend;

    logic              w_valid;
    logic [WORD_W-1:0] w_inst;
    logic [WORD_W-1:0] w_pc;
    logic              w_skid_valid;
    logic [WORD_W-1:0] w_skid_inst;
    logic [WORD_W-1:0] w_skid_pc;

    logic              w_rsp_load;
    logic              w_rsp_skid;
    logic              w_skid_move;
    logic              w_advance;
    logic              w_redir_take;
    logic [WORD_W-1:0] w_pc_adv;
    logic              w_req;
    logic [WORD_W-1:0] w_addr;
    logic [WORD_W-1:0] w_load_inst;
    logic [WORD_W-1:0] w_load_pc;

    // Response goes straight to IF/ID unless decode is stalled on a real instruction.
    assign w_rsp_load  = (r_state == S_WAIT) && fetch_bus.imem_rvalid_i &&
                         (!w_valid || !fetch_bus.pause_i);
    assign w_rsp_skid  = (r_state == S_WAIT) && fetch_bus.imem_rvalid_i &&
                         w_valid && fetch_bus.pause_i;
    assign w_skid_move = (r_state == S_FULL) && !fetch_bus.pause_i;

    // Every IF/ID load frees the single outstanding slot, so the PC advances
    // and the next read issues in the same cycle.
    assign w_advance    = w_rsp_load || w_skid_move;
    assign w_redir_take = fetch_bus.redirect_i && w_valid && !fetch_bus.pause_i;
    assign w_pc_adv     = r_redir_pend ? r_redir_tgt : pc_incr(r_fetch_pc);

    assign w_req  = !rst && ((r_state == S_IDLE) || w_advance);
    assign w_addr = w_advance ? w_pc_adv : r_fetch_pc;

    assign w_load_inst = w_skid_valid ? w_skid_inst : fetch_bus.imem_rdata_i;
    assign w_load_pc   = w_skid_valid ? w_skid_pc : r_fetch_pc;

    // Fetch FSM together with the fetch PC and pending-redirect bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_redir_tgt  <= '0;
            r_redir_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_WAIT;
                S_WAIT:  if (w_rsp_skid) r_state <= S_FULL;
                S_FULL:  if (w_skid_move) r_state <= S_WAIT;
                default: r_state <= S_IDLE;
            endcase

            if (w_advance) begin
                r_fetch_pc <= w_pc_adv;
            end

            // A redirect in the same cycle as an advance applies to the next advance.
            if (w_redir_take) begin
                r_redir_pend <= 1'b1;
                r_redir_tgt  <= fetch_bus.redirect_pc_i;
            end else if (w_advance) begin
                r_redir_pend <= 1'b0;
            end
        end
    end

    if_id_reg #(
        .INST_NOP (INST_NOP)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_advance),
        .i_bubble (!fetch_bus.pause_i),
        .i_inst   (w_load_inst),
        .i_pc     (w_load_pc),
        .o_inst   (w_inst),
        .o_pc     (w_pc),
        .o_valid  (w_valid)
    );

    // Skid entry: filled when a response lands during a stall, drained on release.
    if_id_reg #(
        .INST_NOP (INST_NOP)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_rsp_skid),
        .i_bubble (w_skid_move),
        .i_inst   (fetch_bus.imem_rdata_i),
        .i_pc     (r_fetch_pc),
        .o_inst   (w_skid_inst),
        .o_pc     (w_skid_pc),
        .o_valid  (w_skid_valid)
    );

    assign fetch_bus.imem_req_o  = w_req;
    assign fetch_bus.imem_addr_o = w_addr;
    assign fetch_bus.inst_o      = w_inst;
    assign fetch_bus.pc_o        = w_pc;
    assign fetch_bus.valid_o     = w_valid;

`ifdef INST_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Count IF/ID loads and cycles where decode stalls on a valid instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_advance) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_valid && fetch_bus.pause_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign fetch_bus.perf_fetched_o = r_perf_fetched;
    assign fetch_bus.perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a small latency-configurable memory model
// answers requests; each scenario task checks IF/ID and request addresses.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int          lat      = 1;
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    bit          late_rv  = 1'b0;
    logic        obs_req;
    logic [31:0] obs_addr;
    logic [31:0] req_log[$];

    // One clock cycle: drive decode inputs and memory response, sample the
    // combinational request, then advance past the rising edge.
    task automatic step(input logic p, input logic r, input logic [31:0] rpc);
        bus.pause_i       = p;
        bus.redirect_i    = r;
        bus.redirect_pc_i = rpc;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        if (late_rv) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = 32'hBAD0_BAD0;
            late_rv           = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_addr ^ 32'hDEAD_0000;
                mem_busy          = 1'b0;
            end
        end
        #1;
        obs_req  = bus.imem_req_o;
        obs_addr = bus.imem_addr_o;
        if (obs_req) begin
            tests_run++;
            if (mem_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL outstanding: new req %h while %h pending", obs_addr, mem_addr);
            end
            mem_busy = 1'b1;
            mem_cnt  = lat;
            mem_addr = obs_addr;
            req_log.push_back(obs_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.pause_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        mem_busy          = 1'b0;
        late_rv           = 1'b0;
        req_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        bus.pause_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL rst_valid: got %b want 0", bus.valid_o);
        end
        tests_run++;
        if (bus.inst_o !== 32'h0) begin
            tests_failed++; $display("FAIL rst_inst: got %h want 00000000", bus.inst_o);
        end
        tests_run++;
        if (bus.pc_o !== 32'h0) begin
            tests_failed++; $display("FAIL rst_pc: got %h want 00000000", bus.pc_o);
        end
        tests_run++;
        if (bus.imem_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL rst_req: got %b want 0", bus.imem_req_o);
        end
        tests_run++;
        if (bus.imem_addr_o !== 32'h0) begin
            tests_failed++; $display("FAIL rst_addr: got %h want 00000000", bus.imem_addr_o);
        end
    endtask

    task automatic test_lat1();
        lat = 1;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            tests_failed++; $display("FAIL lat1_req0: got %b/%h want 1/00000000", obs_req, obs_addr);
        end
        tests_run++;
        if (bus.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL lat1_valid0: got %b want 0", bus.valid_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin
            tests_failed++; $display("FAIL lat1_req4: got %b/%h want 1/00000004", obs_req, obs_addr);
        end
        tests_run++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.inst_o !== 32'hDEAD_0000) begin
            tests_failed++;
            $display("FAIL lat1_ifid0: got %b/%h/%h want 1/00000000/dead0000",
                     bus.valid_o, bus.pc_o, bus.inst_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h8) begin
            tests_failed++; $display("FAIL lat1_req8: got %h want 00000008", obs_addr);
        end
        tests_run++;
        if (bus.pc_o !== 32'h4 || bus.inst_o !== 32'hDEAD_0004) begin
            tests_failed++;
            $display("FAIL lat1_ifid4: got %h/%h want 00000004/dead0004", bus.pc_o, bus.inst_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h8 || bus.inst_o !== 32'hDEAD_0008) begin
            tests_failed++;
            $display("FAIL lat1_ifid8: got %b/%h/%h want 1/00000008/dead0008",
                     bus.valid_o, bus.pc_o, bus.inst_o);
        end
    endtask

    task automatic test_lat3();
        lat = 3;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL lat3_wait: valid got %b want 0", bus.valid_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h4 || bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL lat3_first: got %h/%b/%h want 00000004/1/00000000",
                     obs_addr, bus.valid_o, bus.pc_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.valid_o !== 1'b0 || bus.inst_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL lat3_bubble: got %b/%h want 0/00000000", bus.valid_o, bus.inst_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_req !== 1'b0) begin
            tests_failed++; $display("FAIL lat3_noreq: got %b want 0", obs_req);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h8 || bus.valid_o !== 1'b1 || bus.inst_o !== 32'hDEAD_0004) begin
            tests_failed++;
            $display("FAIL lat3_second: got %h/%b/%h want 00000008/1/dead0004",
                     obs_addr, bus.valid_o, bus.inst_o);
        end
    endtask

    task automatic test_pause();
        lat = 1;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            tests_run++;
            if (obs_req !== 1'b0 || bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0 ||
                bus.inst_o !== 32'hDEAD_0000) begin
                tests_failed++;
                $display("FAIL pause_hold%0d: got %b/%b/%h/%h want 0/1/00000000/dead0000",
                         i, obs_req, bus.valid_o, bus.pc_o, bus.inst_o);
            end
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin
            tests_failed++; $display("FAIL pause_rel_req: got %b/%h want 1/00000008", obs_req, obs_addr);
        end
        tests_run++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h4 || bus.inst_o !== 32'hDEAD_0004) begin
            tests_failed++;
            $display("FAIL pause_skid: got %b/%h/%h want 1/00000004/dead0004",
                     bus.valid_o, bus.pc_o, bus.inst_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.pc_o !== 32'h8 || bus.inst_o !== 32'hDEAD_0008) begin
            tests_failed++;
            $display("FAIL pause_after: got %h/%h want 00000008/dead0008", bus.pc_o, bus.inst_o);
        end
    endtask

    task automatic test_branch();
        bit found18;
        lat = 2;
        do_reset();
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h10 || bus.inst_o !== 32'hDEAD_0010) begin
            tests_failed++;
            $display("FAIL br_at10: got %b/%h/%h want 1/00000010/dead0010",
                     bus.valid_o, bus.pc_o, bus.inst_o);
        end
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h100 || bus.pc_o !== 32'h14 || bus.inst_o !== 32'hDEAD_0014) begin
            tests_failed++;
            $display("FAIL br_slot: got %h/%h/%h want 00000100/00000014/dead0014",
                     obs_addr, bus.pc_o, bus.inst_o);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h104 || bus.pc_o !== 32'h100 || bus.inst_o !== 32'hDEAD_0100) begin
            tests_failed++;
            $display("FAIL br_tgt: got %h/%h/%h want 00000104/00000100/dead0100",
                     obs_addr, bus.pc_o, bus.inst_o);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.pc_o !== 32'h104 || bus.valid_o !== 1'b1) begin
            tests_failed++; $display("FAIL br_tgt4: got %h/%b want 00000104/1", bus.pc_o, bus.valid_o);
        end
        found18 = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 32'h18) found18 = 1'b1;
        tests_run++;
        if (found18 !== 1'b0) begin
            tests_failed++; $display("FAIL br_no18: address 00000018 requested, want never");
        end
    endtask

    task automatic test_redirect_pause();
        lat = 2;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        tests_run++;
        if (obs_req !== 1'b0 || bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rp_hold: got %b/%b/%h want 0/1/00000000", obs_req, bus.valid_o, bus.pc_o);
        end
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        tests_run++;
        if (obs_addr !== 32'h8 || bus.pc_o !== 32'h4) begin
            tests_failed++;
            $display("FAIL rp_same_cycle: got %h/%h want 00000008/00000004", obs_addr, bus.pc_o);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'hFFFF_FFFC || bus.pc_o !== 32'h8) begin
            tests_failed++;
            $display("FAIL rp_target: got %h/%h want fffffffc/00000008", obs_addr, bus.pc_o);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h0 || bus.pc_o !== 32'hFFFF_FFFC || bus.inst_o !== 32'h2152_FFFC) begin
            tests_failed++;
            $display("FAIL rp_wrap: got %h/%h/%h want 00000000/fffffffc/2152fffc",
                     obs_addr, bus.pc_o, bus.inst_o);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_addr !== 32'h4 || bus.pc_o !== 32'h0 || bus.inst_o !== 32'hDEAD_0000) begin
            tests_failed++;
            $display("FAIL rp_once: got %h/%h/%h want 00000004/00000000/dead0000",
                     obs_addr, bus.pc_o, bus.inst_o);
        end
    endtask

    task automatic test_reset_mid();
        lat = 3;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== 32'h0 || bus.inst_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_rst_ifid: got %b/%h/%h want 0/00000000/00000000",
                     bus.valid_o, bus.pc_o, bus.inst_o);
        end
        tests_run++;
        if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_rst_req: got %b/%h want 0/00000000", bus.imem_req_o, bus.imem_addr_o);
        end
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        bus.imem_rvalid_i = 1'b0;
        mem_busy          = 1'b0;
        req_log.delete();
        rst               = 1'b0;
        late_rv           = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0 || bus.valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_restart: got %b/%h/%b want 1/00000000/0", obs_req, obs_addr, bus.valid_o);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.valid_o !== 1'b0) begin
            tests_failed++; $display("FAIL mid_late_ignored: valid got %b want 0", bus.valid_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.inst_o !== 32'hDEAD_0000) begin
            tests_failed++;
            $display("FAIL mid_first: got %b/%h/%h want 1/00000000/dead0000",
                     bus.valid_o, bus.pc_o, bus.inst_o);
        end
    endtask

    initial begin
        test_reset();
        test_lat1();
        test_lat3();
        test_pause();
        test_branch();
        test_redirect_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
